// File: rtl/arbiter.sv
// ---------------------------------------------------------------------------
// arbiter
//   Two-requester, non-preemptive arbiter for a shared resource. A grant is
//   held for as long as its owner keeps requesting. When both masters request
//   while the resource is free, the 2-bit priorities decide. A priority tie
//   goes to whichever master did not win the previous grant.
//
// Ports
//   clk  in   system clock, rising-edge active
//   rst  in   synchronous active-high reset
//   ra   in   request from master A (level, held while ownership is wanted)
//   rb   in   request from master B
//   PA   in   [1:0] priority of A, unsigned, larger wins
//   PB   in   [1:0] priority of B, unsigned, larger wins
//   ga   out  grant to A, registered
//   gb   out  grant to B, registered
// ---------------------------------------------------------------------------
module arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       ra,
  input  logic       rb,
  input  logic [1:0] PA,
  input  logic [1:0] PB,
  output logic       ga,
  output logic       gb
);

  typedef enum logic [1:0] {
    WAIT_REQ = 2'b00,
    GRANT_A  = 2'b01,
    GRANT_B  = 2'b10
  } state_t;

  state_t r_state;
  logic   r_last_b;  // 1 when the most recent grant went to B
  logic   r_ga;
  logic   r_gb;

  // Contest resolution when both request while the resource is free:
  // strict priority first, then alternate against the last winner.
  function automatic logic pick_a(input logic [1:0] pa,
                                  input logic [1:0] pb,
                                  input logic       last_b);
    logic win_a;
    if (pa > pb) begin
      win_a = 1'b1;
    end else if (pb > pa) begin
      win_a = 1'b0;
    end else begin
      win_a = last_b;
    end
    return win_a;
  endfunction

  logic w_pick_a;
  assign w_pick_a = pick_a(PA, PB, r_last_b);

  assign ga = r_ga;
  assign gb = r_gb;

  // State machine: next state, Moore grant registers and last-winner flag.
  // Grants are registered alongside the state so they never follow inputs
  // combinationally; they are only ever set in mutually exclusive branches.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= WAIT_REQ;
      r_ga     <= 1'b0;
      r_gb     <= 1'b0;
      r_last_b <= 1'b1;  // A wins the first tie after reset
    end else begin
      case (r_state)
        WAIT_REQ: begin
          if ((ra && !rb) || (ra && rb && w_pick_a)) begin
            r_state  <= GRANT_A;
            r_ga     <= 1'b1;
            r_gb     <= 1'b0;
            r_last_b <= 1'b0;
          end else if (rb) begin
            r_state  <= GRANT_B;
            r_ga     <= 1'b0;
            r_gb     <= 1'b1;
            r_last_b <= 1'b1;
          end else begin
            r_state  <= WAIT_REQ;
            r_ga     <= 1'b0;
            r_gb     <= 1'b0;
            r_last_b <= r_last_b;
          end
        end
        GRANT_A: begin
          if (ra) begin
            r_state  <= GRANT_A;
            r_ga     <= 1'b1;
            r_gb     <= 1'b0;
            r_last_b <= r_last_b;
          end else if (rb) begin
            // Direct handoff, no idle cycle in between
            r_state  <= GRANT_B;
            r_ga     <= 1'b0;
            r_gb     <= 1'b1;
            r_last_b <= 1'b1;
          end else begin
            r_state  <= WAIT_REQ;
            r_ga     <= 1'b0;
            r_gb     <= 1'b0;
            r_last_b <= r_last_b;
          end
        end
        GRANT_B: begin
          if (rb) begin
            r_state  <= GRANT_B;
            r_ga     <= 1'b0;
            r_gb     <= 1'b1;
            r_last_b <= r_last_b;
          end else if (ra) begin
            r_state  <= GRANT_A;
            r_ga     <= 1'b1;
            r_gb     <= 1'b0;
            r_last_b <= 1'b0;
          end else begin
            r_state  <= WAIT_REQ;
            r_ga     <= 1'b0;
            r_gb     <= 1'b0;
            r_last_b <= r_last_b;
          end
        end
        default: begin
          // Unreachable encoding: recover to the free state with no grant
          r_state  <= WAIT_REQ;
          r_ga     <= 1'b0;
          r_gb     <= 1'b0;
          r_last_b <= r_last_b;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter.sv
module tb_arbiter;

  logic       clk;
  logic       rst;
  logic       ra;
  logic       rb;
  logic [1:0] PA;
  logic [1:0] PB;
  logic       ga;
  logic       gb;

  int n_cmp;
  int n_err;

  arbiter dut (
    .clk (clk),
    .rst (rst),
    .ra  (ra),
    .rb  (rb),
    .PA  (PA),
    .PB  (PB),
    .ga  (ga),
    .gb  (gb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; ra = 1'b1; rb = 1'b1; PA = 2'd0; PB = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({ga, gb} !== 2'b00) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d got ga,gb=%b%b want 00", i, ga, gb);
      end
    end
    rst = 1'b0; ra = 1'b0; rb = 1'b0;
    tick();
    n_cmp++;
    if ({ga, gb} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle got ga,gb=%b%b want 00", ga, gb);
    end
  endtask

  task automatic test_solo_a;
    ra = 1'b1; rb = 1'b0;
    #1;
    // Request just raised: grant must not appear before the edge
    n_cmp++;
    if ({ga, gb} !== 2'b00) begin
      n_err++;
      $display("FAIL solo_a_no_comb got ga,gb=%b%b want 00", ga, gb);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({ga, gb} !== 2'b10) begin
        n_err++;
        $display("FAIL solo_a_hold cyc=%0d got ga,gb=%b%b want 10", i, ga, gb);
      end
    end
  endtask

  task automatic test_ownership;
    // Still in GrantA: higher-priority B must not preempt
    rb = 1'b1; PA = 2'd0; PB = 2'd3;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if ({ga, gb} !== 2'b10) begin
        n_err++;
        $display("FAIL ownership cyc=%0d got ga,gb=%b%b want 10", i, ga, gb);
      end
    end
  endtask

  task automatic test_handoff;
    ra = 1'b0;  // rb still 1
    tick();
    n_cmp++;
    if ({ga, gb} !== 2'b01) begin
      n_err++;
      $display("FAIL handoff_a_to_b got ga,gb=%b%b want 01", ga, gb);
    end
    ra = 1'b1; rb = 1'b0;
    tick();
    n_cmp++;
    if ({ga, gb} !== 2'b10) begin
      n_err++;
      $display("FAIL handoff_b_to_a got ga,gb=%b%b want 10", ga, gb);
    end
    ra = 1'b0;
    tick();
    n_cmp++;
    if ({ga, gb} !== 2'b00) begin
      n_err++;
      $display("FAIL release_to_idle got ga,gb=%b%b want 00", ga, gb);
    end
  endtask

  task automatic test_reset_mid_grant;
    ra = 1'b1;
    tick();
    n_cmp++;
    if ({ga, gb} !== 2'b10) begin
      n_err++;
      $display("FAIL mid_grant_setup got ga,gb=%b%b want 10", ga, gb);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({ga, gb} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_in_grant got ga,gb=%b%b want 00", ga, gb);
    end
    rst = 1'b0; ra = 1'b0;
    tick();
  endtask

  task automatic test_priority;
    ra = 1'b1; rb = 1'b1; PA = 2'd1; PB = 2'd2;
    tick();
    n_cmp++;
    if ({ga, gb} !== 2'b01) begin
      n_err++;
      $display("FAIL prio_b_wins got ga,gb=%b%b want 01", ga, gb);
    end
    ra = 1'b0; rb = 1'b0;
    tick();
    PA = 2'd3; PB = 2'd0; ra = 1'b1; rb = 1'b1;
    tick();
    n_cmp++;
    if ({ga, gb} !== 2'b10) begin
      n_err++;
      $display("FAIL prio_a_wins got ga,gb=%b%b want 10", ga, gb);
    end
    ra = 1'b0; rb = 1'b0;
    tick();
  endtask

  task automatic test_tie;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    PA = 2'd2; PB = 2'd2; ra = 1'b1; rb = 1'b1;
    tick();
    n_cmp++;
    if ({ga, gb} !== 2'b10) begin
      n_err++;
      $display("FAIL tie_first got ga,gb=%b%b want 10", ga, gb);
    end
    ra = 1'b0; rb = 1'b0;
    tick();
    ra = 1'b1; rb = 1'b1;
    tick();
    n_cmp++;
    if ({ga, gb} !== 2'b01) begin
      n_err++;
      $display("FAIL tie_second got ga,gb=%b%b want 01", ga, gb);
    end
    ra = 1'b0; rb = 1'b0;
    tick();
    ra = 1'b1; rb = 1'b1;
    tick();
    n_cmp++;
    if ({ga, gb} !== 2'b10) begin
      n_err++;
      $display("FAIL tie_third got ga,gb=%b%b want 10", ga, gb);
    end
    ra = 1'b0; rb = 1'b0;
    tick();
    n_cmp++;
    if ({ga, gb} !== 2'b00) begin
      n_err++;
      $display("FAIL tie_release got ga,gb=%b%b want 00", ga, gb);
    end
  endtask

  task automatic test_solo_b;
    // B alone holds indefinitely, A's higher priority ignored once granted
    rb = 1'b1; PA = 2'd0; PB = 2'd0;
    tick();
    n_cmp++;
    if ({ga, gb} !== 2'b01) begin
      n_err++;
      $display("FAIL solo_b_grant got ga,gb=%b%b want 01", ga, gb);
    end
    ra = 1'b1; PA = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({ga, gb} !== 2'b01) begin
        n_err++;
        $display("FAIL solo_b_hold cyc=%0d got ga,gb=%b%b want 01", i, ga, gb);
      end
    end
    ra = 1'b0; rb = 1'b0;
    tick();
    n_cmp++;
    if ({ga, gb} !== 2'b00) begin
      n_err++;
      $display("FAIL solo_b_release got ga,gb=%b%b want 00", ga, gb);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; ra = 1'b0; rb = 1'b0; PA = 2'd0; PB = 2'd0;
    #2;
    test_reset();
    test_solo_a();
    test_ownership();
    test_handoff();
    test_reset_mid_grant();
    test_priority();
    test_tie();
    test_solo_b();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
